// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory responder: access sizes, FSM states
// and the wait-state counter width.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/dmem_lane_align.sv
// Little-endian lane steering: byte enables and replicated store data for
// writes, lane extraction plus sign/zero extension for loads.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  addr,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wdata_sh,
    output logic [31:0] ldata,
    output logic        misalign
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        be       = 4'b0000;
        wdata_sh = wdata;
        ldata    = 32'h0;
        misalign = 1'b0;
        lane_b   = rword[{addr, 3'b000} +: 8];
        lane_h   = addr[1] ? rword[31:16] : rword[15:0];
        case (size)
            SZ_BYTE: begin
                be       = 4'b0001 << addr;
                wdata_sh = {4{wdata[7:0]}};
                ldata    = is_unsigned ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
            end
            SZ_HALF: begin
                misalign = addr[0];
                be       = addr[1] ? 4'b1100 : 4'b0011;
                wdata_sh = {2{wdata[15:0]}};
                ldata    = is_unsigned ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
            end
            SZ_WORD: begin
                misalign = (addr != 2'b00);
                be       = 4'b1111;
                ldata    = rword;
            end
            default: begin
                misalign = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM with LATENCY wait states, stalls the
// pipeline while an access is in flight and presents load data in DONE.
//
// state | meaning
// IDLE  | waiting; a request is latched and the stage is stalled
// BUSY  | wait states counting down; access performed at terminal count
// DONE  | result presented on RD/MemErrM, stall released for one cycle
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [1:0]  MemSizeM,
    input  logic        MemUnsignedM,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] RD,
    output logic        StallM,
    output logic        MemErrM
);

    localparam int AW = $clog2(DEPTH_WORDS);

    state_e           state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic [AW+1:0]    addr_q;
    logic [1:0]       size_q;
    logic             uns_q;
    logic             wr_q;
    logic [31:0]      wdata_q;
    logic [31:0]      rd_q;
    logic             err_q;

    logic [31:0]      mem [DEPTH_WORDS];

    logic             req;
    logic             fire;
    logic [31:0]      rword;
    logic [3:0]       be;
    logic [31:0]      wdata_sh;
    logic [31:0]      ldata;
    logic             misalign;
    logic             addr_unused;

    // Upper address bits alias onto the RAM, so they are deliberately dropped.
    assign addr_unused = ^ALUOutM[31:AW+2];

    assign req   = MemReadM | MemWriteM;
    assign fire  = (state == ST_BUSY) && (cnt == '0);
    assign rword = mem[addr_q[AW+1:2]];

    dmem_lane_align u_align (
        .addr        (addr_q[1:0]),
        .size        (size_q),
        .is_unsigned (uns_q),
        .wdata       (wdata_q),
        .rword       (rword),
        .be          (be),
        .wdata_sh    (wdata_sh),
        .ldata       (ldata),
        .misalign    (misalign)
    );

    always_comb begin
        state_nx = state;
        StallM   = 1'b0;
        RD       = 32'h0;
        MemErrM  = 1'b0;
        case (state)
            ST_IDLE: begin
                StallM = req;
                if (req) state_nx = ST_BUSY;
            end
            ST_BUSY: begin
                StallM = 1'b1;
                if (cnt == '0) state_nx = ST_DONE;
            end
            ST_DONE: begin
                RD       = rd_q;
                MemErrM  = err_q;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
        if (!rst_n) begin
            StallM  = 1'b0;
            RD      = 32'h0;
            MemErrM = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            rd_q  <= 32'h0;
            err_q <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == ST_IDLE && req) begin
                cnt <= CNT_W'(LATENCY - 1);
            end else if (state == ST_BUSY && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (fire) begin
                rd_q  <= (wr_q || misalign) ? 32'h0 : ldata;
                err_q <= misalign;
            end
        end
    end

    // Request fields are only consumed while BUSY, so they need no reset.
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && req) begin
            addr_q  <= ALUOutM[AW+1:0];
            size_q  <= MemSizeM;
            uns_q   <= MemUnsignedM;
            wr_q    <= MemWriteM;
            wdata_q <= WriteDataM;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && fire && wr_q && !misalign) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[addr_q[AW+1:2]][8*i +: 8] <= wdata_sh[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed vector table on a LATENCY=1 instance,
// mid-access reset on a LATENCY=3 instance, randomized ops against a byte model.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst_n [2];
    logic        mr    [2];
    logic        mw    [2];
    logic [1:0]  ms    [2];
    logic        mu    [2];
    logic [31:0] ad    [2];
    logic [31:0] wd    [2];
    logic [31:0] rdo   [2];
    logic        st    [2];
    logic        er    [2];

    int checks = 0;
    int errors = 0;

    localparam int LAT0 = 1;
    localparam int LAT1 = 3;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(LAT0)) u_lat1 (
        .clk(clk), .rst_n(rst_n[0]), .MemReadM(mr[0]), .MemWriteM(mw[0]),
        .MemSizeM(ms[0]), .MemUnsignedM(mu[0]), .ALUOutM(ad[0]),
        .WriteDataM(wd[0]), .RD(rdo[0]), .StallM(st[0]), .MemErrM(er[0])
    );

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(LAT1)) u_lat3 (
        .clk(clk), .rst_n(rst_n[1]), .MemReadM(mr[1]), .MemWriteM(mw[1]),
        .MemSizeM(ms[1]), .MemUnsignedM(mu[1]), .ALUOutM(ad[1]),
        .WriteDataM(wd[1]), .RD(rdo[1]), .StallM(st[1]), .MemErrM(er[1])
    );

    typedef struct {
        logic        r;
        logic        w;
        logic [1:0]  sz;
        logic        u;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] erd;
        logic        eerr;
    } vec_t;

    vec_t tbl [16];

    // Byte-level memory image for addresses 0..63 (bits 11:6 kept zero so upper bits alias here).
    logic [7:0] mem_b [64];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, act, exp);
        end
    endtask

    task automatic do_access(input int s, input logic r, input logic w, input logic [1:0] sz,
                             input logic u, input logic [31:0] a, input logic [31:0] d,
                             output logic [31:0] ro, output logic eo, output int ns);
        bit done;
        mr[s] = r; mw[s] = w; ms[s] = sz; mu[s] = u; ad[s] = a; wd[s] = d;
        ro = 32'h0; eo = 1'b0; ns = 0; done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            #1;
            if (st[s]) begin
                ns++;
                @(negedge clk);
            end else begin
                ro = rdo[s];
                eo = er[s];
                done = 1;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL access_timeout actual stall_held required done_within_40");
        end
        @(negedge clk);
        mr[s] = 1'b0; mw[s] = 1'b0;
    endtask

    function automatic void model(input logic r, input logic w, input logic [1:0] sz,
                                  input logic u, input logic [31:0] a, input logic [31:0] d,
                                  output logic [31:0] erd, output logic eerr);
        int nb;
        logic [31:0] v;
        logic mis;
        nb  = 1 << sz;
        mis = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
        erd = 32'h0;
        eerr = mis;
        if (!mis) begin
            if (w) begin
                for (int k = 0; k < nb; k++) mem_b[int'(a[5:0]) + k] = d[8*k +: 8];
            end else if (r) begin
                v = 32'h0;
                for (int k = 0; k < nb; k++) v = v | (32'(mem_b[int'(a[5:0]) + k]) << (8*k));
                if (nb < 4 && !u && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
                erd = v;
            end
        end
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ro, erd;
        logic        eo, eerr;
        int          ns;

        tbl[0]  = '{1'b0, 1'b1, 2'd2, 1'b0, 32'h10,   32'hDEADBEEF, 32'h0,        1'b0};
        tbl[1]  = '{1'b1, 1'b0, 2'd2, 1'b0, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 2'd0, 1'b0, 32'h13,   32'h0,        32'hFFFFFFDE, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 2'd0, 1'b1, 32'h13,   32'h0,        32'h000000DE, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 2'd1, 1'b0, 32'h12,   32'h00001234, 32'h0,        1'b0};
        tbl[5]  = '{1'b1, 1'b0, 2'd2, 1'b0, 32'h10,   32'h0,        32'h1234BEEF, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 2'd2, 1'b0, 32'h11,   32'hFFFFFFFF, 32'h0,        1'b1};
        tbl[7]  = '{1'b1, 1'b0, 2'd2, 1'b0, 32'h10,   32'h0,        32'h1234BEEF, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 2'd3, 1'b0, 32'h10,   32'h0,        32'h0,        1'b1};
        tbl[9]  = '{1'b0, 1'b1, 2'd2, 1'b0, 32'h1000, 32'hCAFEF00D, 32'h0,        1'b0};
        tbl[10] = '{1'b1, 1'b0, 2'd2, 1'b0, 32'h0,    32'h0,        32'hCAFEF00D, 1'b0};
        tbl[11] = '{1'b1, 1'b1, 2'd2, 1'b0, 32'h20,   32'h11112222, 32'h0,        1'b0};
        tbl[12] = '{1'b1, 1'b0, 2'd2, 1'b0, 32'h20,   32'h0,        32'h11112222, 1'b0};
        tbl[13] = '{1'b1, 1'b0, 2'd1, 1'b0, 32'h12,   32'h0,        32'h00001234, 1'b0};
        tbl[14] = '{1'b1, 1'b0, 2'd1, 1'b0, 32'h11,   32'h0,        32'h0,        1'b1};
        tbl[15] = '{1'b1, 1'b0, 2'd1, 1'b0, 32'h10,   32'h0,        32'hFFFFBEEF, 1'b0};

        for (int s = 0; s < 2; s++) begin
            rst_n[s] = 1'b0; mr[s] = 1'b0; mw[s] = 1'b0; ms[s] = 2'd0;
            mu[s] = 1'b0; ad[s] = 32'h0; wd[s] = 32'h0;
        end

        // Reset held with a request pending must not stall.
        repeat (2) @(negedge clk);
        mr[0] = 1'b1;
        #1;
        chk("reset_stall_req", 32'(st[0]), 32'h0);
        for (int s = 0; s < 2; s++) begin
            chk("reset_stall", 32'(st[s]), 32'h0);
            chk("reset_rd",    rdo[s],     32'h0);
            chk("reset_err",   32'(er[s]), 32'h0);
        end
        @(negedge clk);
        mr[0] = 1'b0;
        rst_n[0] = 1'b1; rst_n[1] = 1'b1;
        @(negedge clk);
        #1;
        chk("idle_stall", 32'(st[0]), 32'h0);
        @(negedge clk);

        for (int i = 0; i < 16; i++) begin
            do_access(0, tbl[i].r, tbl[i].w, tbl[i].sz, tbl[i].u, tbl[i].a, tbl[i].d, ro, eo, ns);
            chk($sformatf("vec%0d_rd", i),    ro,      tbl[i].erd);
            chk($sformatf("vec%0d_err", i),   32'(eo), 32'(tbl[i].eerr));
            chk($sformatf("vec%0d_stall", i), ns,      LAT0 + 1);
        end

        // LATENCY=3: reset pulsed while a store is in BUSY drops the store.
        do_access(1, 1'b0, 1'b1, 2'd2, 1'b0, 32'h40, 32'hAAAA5555, ro, eo, ns);
        chk("l3_store_stall", ns, LAT1 + 1);
        mw[1] = 1'b1; ms[1] = 2'd2; ad[1] = 32'h40; wd[1] = 32'h12345678;
        @(negedge clk);
        #1;
        chk("l3_busy_stall", 32'(st[1]), 32'h1);
        rst_n[1] = 1'b0;
        @(negedge clk);
        #1;
        chk("l3_rst_stall", 32'(st[1]), 32'h0);
        chk("l3_rst_rd",    rdo[1],     32'h0);
        chk("l3_rst_err",   32'(er[1]), 32'h0);
        mw[1] = 1'b0;
        rst_n[1] = 1'b1;
        @(negedge clk);
        #1;
        chk("l3_idle_stall", 32'(st[1]), 32'h0);
        do_access(1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0, ro, eo, ns);
        chk("l3_old_data",  ro,      32'hAAAA5555);
        chk("l3_load_err",  32'(eo), 32'h0);
        chk("l3_load_stall", ns,     LAT1 + 1);

        // Randomized traffic on the LATENCY=1 instance against the byte model.
        for (int w = 0; w < 16; w++) begin
            logic [31:0] d;
            d = $urandom;
            model(1'b0, 1'b1, 2'd2, 1'b0, 32'(w * 4), d, erd, eerr);
            do_access(0, 1'b0, 1'b1, 2'd2, 1'b0, 32'(w * 4), d, ro, eo, ns);
            chk("init_err", 32'(eo), 32'(eerr));
        end
        for (int n = 0; n < 200; n++) begin
            logic r, w, u;
            logic [1:0] sz;
            logic [31:0] a, d;
            int op;
            op = $urandom_range(0, 4);
            r  = (op != 1) && (op != 2);
            w  = (op == 1) || (op == 2) || (op == 4);
            sz = 2'($urandom_range(0, 3));
            u  = 1'($urandom_range(0, 1));
            a  = $urandom & 32'hFFFF_F03F;
            d  = $urandom;
            model(r, w, sz, u, a, d, erd, eerr);
            do_access(0, r, w, sz, u, a, d, ro, eo, ns);
            chk($sformatf("rand%0d_rd a=%h sz=%0d w=%0b", n, a, sz, w), ro, erd);
            chk($sformatf("rand%0d_err", n), 32'(eo), 32'(eerr));
            chk($sformatf("rand%0d_stall", n), ns, LAT0 + 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
